multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset datapath. It replaces single-cycle decode with a state sequencer that shares one memory port between instruction fetch and data access.
- Decodes opcode/funct, including custom ops bn and jrsal, and drives per-state datapath enables.
- Waits on a memory ready handshake, with a bus-error watchdog.
- Sits between the instruction register and the shared datapath (PC, register file, ALU, memory mux).

---
 rtl/multicycle_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl_waitcnt.sv | 34 +++
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_defs: shared definitions for the multi-cycle MIPS-subset controller.
//   - state_t     : sequencer state encodings (also exported on the debug port)
//   - OP_* / FUNCT_JR : opcode and funct constants decoded by the controller
//   - PCSRC_*, ALUB_*, M2R_*, REGDST_*, ALUOP_* : datapath mux select codes
//   - is_wait_state() : states that hold for the memory ready handshake
// ----------------------------------------------------------------------------
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMPR  = 4'd9,
        S_JRSRD  = 4'd10,
        S_JRSWB  = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BN    = 6'b100101;
    localparam logic [5:0] OP_JRSAL = 6'b011001;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_RS     = 2'd2;
    localparam logic [1:0] PCSRC_MDR    = 2'd3;

    localparam logic [1:0] ALUB_RT     = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMMSH2 = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // States that sit on the shared memory port waiting for memready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR) || (s == S_JRSRD);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if: control bundle between the sequencer and the datapath.
//   master : the controller (consumes IR fields / flags, drives enables)
//   slave  : the datapath   (drives IR fields / flags, consumes enables)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       pcwrite;
    logic       pcwritecond;
    logic       branchne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdest;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       buserr;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memready,
        output pcwrite, pcwritecond, branchne, iord, memread, memwrite, irwrite,
               regdest, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource,
               buserr, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcwrite, pcwritecond, branchne, iord, memread, memwrite, irwrite,
               regdest, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource,
               buserr, state
    );
endinterface

// File: rtl/multicycle_ctrl_waitcnt.sv
// ----------------------------------------------------------------------------
// mc_waitcnt: memory-handshake watchdog counter.
//   clk, resetn : clock, async active-low reset
//   enable      : count this cycle (waiting on memory, memready low)
//   clear       : sequencer changes state; restart the count (wins over enable)
//   expired     : count has reached WAITMAX
// The count saturates at all-ones so it can never wrap back to a small value.
// ----------------------------------------------------------------------------
module mc_waitcnt #(
    parameter int WAITMAX = 15,
    parameter int CNTW    = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam logic [CNTW-1:0] LP_MAX = CNTW'(WAITMAX);

    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable && (r_cnt != '1))
            r_cnt <= r_cnt + CNTW'(1);
    end

    assign expired = (r_cnt == LP_MAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl: state sequencer for the multi-cycle MIPS-subset datapath.
//   clk, resetn : clock, async active-low reset
//   ctl         : multicycle_ctrl_if.master
//                 in : op, funct (from IR), zero (ALU), memready (memory)
//                 out: datapath enables/selects, sticky buserr, debug state
// Outputs are decoded from the current state. The one exception is FETCH,
// where irwrite/pcwrite follow memready so the IR and PC load only in the
// cycle the instruction word actually arrives. Strobes are gated by resetn
// so they are all low while reset is held, even though reset parks in FETCH.
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int WAITMAX = 15,
    parameter int CNTW    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    multicycle_ctrl_if.master ctl
);

    state_t r_state;
    state_t w_next;
    logic   r_buserr;
    logic   w_wait;
    logic   w_expired;
    logic   w_trip;
    logic   w_clear;

    // Strobe/select decode before reset gating
    logic       w_pcwrite, w_pcwritecond, w_memread, w_memwrite, w_irwrite, w_regwrite;
    logic       w_branchne, w_iord, w_alusrca;
    logic [1:0] w_regdest, w_memtoreg, w_alusrcb, w_aluop, w_pcsource;

    // ---------------------------------------------------------------- watchdog
    assign w_wait  = is_wait_state(r_state);
    // memready wins over an expired count: only trip while still waiting.
    assign w_trip  = w_wait && !ctl.memready && w_expired;
    assign w_clear = (w_next != r_state);

    mc_waitcnt #(
        .WAITMAX (WAITMAX),
        .CNTW    (CNTW)
    ) u_waitcnt (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (w_wait && !ctl.memready),
        .clear   (w_clear),
        .expired (w_expired)
    );

    // -------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  if (ctl.memready) w_next = S_DECODE;
            S_DECODE: begin
                if ((ctl.op == OP_LW) || (ctl.op == OP_SW))
                    w_next = S_MEMADR;
                else if (ctl.op == OP_RTYPE)
                    w_next = (ctl.funct == FUNCT_JR) ? S_JUMPR : S_EXEC;
                else if ((ctl.op == OP_BEQ) || (ctl.op == OP_BN))
                    w_next = S_BRANCH;
                else if (ctl.op == OP_JRSAL)
                    w_next = S_JRSRD;
                else
                    w_next = S_TRAP;
            end
            // Only lw/sw reach MEMADR, so anything but sw is a load.
            S_MEMADR: w_next = (ctl.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (ctl.memready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (ctl.memready) w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMPR:  w_next = S_FETCH;
            S_JRSRD:  if (ctl.memready) w_next = S_JRSWB;
            S_JRSWB:  w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
        if (w_trip)
            w_next = S_TRAP;
    end

    // Every path into TRAP raises buserr; only reset lowers it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_FETCH;
            r_buserr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_buserr <= 1'b1;
        end
    end

    // ---------------------------------------------------------- output decode
    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_branchne    = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_regdest     = REGDST_RT;
        w_memtoreg    = M2R_ALUOUT;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = ALUB_RT;
        w_aluop       = ALUOP_ADD;
        w_pcsource    = PCSRC_ALU;
        unique case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = ALUB_FOUR;
                w_irwrite = ctl.memready;
                w_pcwrite = ctl.memready;
            end
            S_DECODE: w_alusrcb = ALUB_IMMSH2;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = M2R_MDR;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                w_regdest  = REGDST_RD;
            end
            S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_aluop       = ALUOP_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = PCSRC_ALUOUT;
                w_branchne    = (ctl.op == OP_BN);
            end
            S_JUMPR: begin
                w_pcwrite  = 1'b1;
                w_pcsource = PCSRC_RS;
            end
            S_JRSRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_JRSWB: begin
                // Target comes from memory; PC still holds PC+4 for the link.
                w_pcwrite  = 1'b1;
                w_pcsource = PCSRC_MDR;
                w_regwrite = 1'b1;
                w_regdest  = REGDST_RA;
                w_memtoreg = M2R_PC;
            end
            default: ;
        endcase
    end

    assign ctl.pcwrite     = w_pcwrite     & resetn;
    assign ctl.pcwritecond = w_pcwritecond & resetn;
    assign ctl.memread     = w_memread     & resetn;
    assign ctl.memwrite    = w_memwrite    & resetn;
    assign ctl.irwrite     = w_irwrite     & resetn;
    assign ctl.regwrite    = w_regwrite    & resetn;
    assign ctl.branchne    = w_branchne;
    assign ctl.iord        = w_iord;
    assign ctl.regdest     = w_regdest;
    assign ctl.memtoreg    = w_memtoreg;
    assign ctl.alusrca     = w_alusrca;
    assign ctl.alusrcb     = w_alusrcb;
    assign ctl.aluop       = w_aluop;
    assign ctl.pcsource    = w_pcsource;
    assign ctl.buserr      = r_buserr;
    assign ctl.state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// Decode table, directed corner sequences, then random instruction streams
// whose expected per-cycle state trace is built from instruction class and
// memory latency.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int WAITMAX = 15;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAITMAX(WAITMAX), .CNTW(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ctl    (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite, irwrite;
        logic [1:0] regdest, memtoreg;
        logic       regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
    } ctl_t;

    function automatic ctl_t act_ctl();
        ctl_t c;
        c = {bus.pcwrite, bus.pcwritecond, bus.branchne, bus.iord, bus.memread,
             bus.memwrite, bus.irwrite, bus.regdest, bus.memtoreg, bus.regwrite,
             bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsource};
        return c;
    endfunction

    // Per-state datapath controls as listed for each state; unlisted = 0.
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic mr);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.memread = 1; c.alusrcb = 1; c.irwrite = mr; c.pcwrite = mr; end
            1:  c.alusrcb = 3;
            2:  begin c.alusrca = 1; c.alusrcb = 2; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2; end
            7:  begin c.regwrite = 1; c.regdest = 1; end
            8:  begin c.alusrca = 1; c.aluop = 1; c.pcwritecond = 1; c.pcsource = 1;
                      c.branchne = (op == 6'b100101); end
            9:  begin c.pcwrite = 1; c.pcsource = 2; end
            10: begin c.memread = 1; c.iord = 1; end
            11: begin c.pcwrite = 1; c.pcsource = 3; c.regwrite = 1; c.regdest = 2;
                      c.memtoreg = 2; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive memready, check state/controls/buserr mid-cycle, advance.
    task automatic cyc(input logic mr, input int exp_st, input logic exp_be, input string tag);
        bus.memready = mr;
        #1;
        chk({tag, " state"}, 32'(bus.state), 32'(exp_st));
        chk({tag, " ctl"}, 32'(act_ctl()), 32'(exp_ctl(exp_st, bus.op, mr)));
        chk({tag, " buserr"}, 32'(bus.buserr), 32'(exp_be));
        @(posedge clk); #1;
    endtask

    // Reset with strobe checks while held; leaves time at posedge+1, first FETCH.
    task automatic do_reset(input string tag);
        bus.memready = 1'b0;
        resetn = 1'b0;
        #1;
        chk({tag, " rst state"}, 32'(bus.state), 32'd0);
        chk({tag, " rst buserr"}, 32'(bus.buserr), 32'd0);
        chk({tag, " rst strobes"},
            32'({bus.memread, bus.memwrite, bus.irwrite, bus.pcwrite, bus.pcwritecond, bus.regwrite}),
            32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         exp_st;
    } vec_t;

    typedef struct {
        logic mr;
        int   st;
    } step_t;

    step_t q[$];

    function automatic void push_wait(input int st, input int d);
        for (int k = 0; k < d; k++) q.push_back('{1'b0, st});
        q.push_back('{1'b1, st});
    endfunction

    function automatic void push_fix(input int st);
        q.push_back('{1'($urandom_range(0, 1)), st});
    endfunction

    function automatic int rnd_delay();
        int r;
        r = $urandom_range(0, 9);
        if (r == 9) return WAITMAX;
        if (r == 8) return WAITMAX - 1;
        return $urandom_range(0, 3);
    endfunction

    vec_t vecs[10];

    initial begin
        bus.op = 6'd0;
        bus.funct = 6'd0;
        bus.zero = 1'b0;
        bus.memready = 1'b0;
        #2;

        // -------------------------------------------------- decode table
        vecs[0] = '{6'b100011, 6'b000000, 2};
        vecs[1] = '{6'b101011, 6'b000000, 2};
        vecs[2] = '{6'b000000, 6'b100000, 6};
        vecs[3] = '{6'b000000, 6'b001000, 9};
        vecs[4] = '{6'b000000, 6'b001001, 6};
        vecs[5] = '{6'b000100, 6'b000000, 8};
        vecs[6] = '{6'b100101, 6'b000000, 8};
        vecs[7] = '{6'b011001, 6'b000000, 10};
        vecs[8] = '{6'b111111, 6'b000000, 15};
        vecs[9] = '{6'b000010, 6'b000000, 15};
        for (int i = 0; i < 10; i++) begin
            do_reset("dec");
            bus.op = vecs[i].op;
            bus.funct = vecs[i].funct;
            cyc(1'b1, 0, 1'b0, "dec fetch");
            cyc(1'b1, 1, 1'b0, "dec decode");
            cyc(1'b1, vecs[i].exp_st, vecs[i].exp_st == 15, "dec next");
        end

        // -------------------------------------------------- R-type add
        do_reset("radd");
        bus.op = 6'b000000; bus.funct = 6'b100000;
        cyc(1, 0, 0, "radd"); cyc(1, 1, 0, "radd"); cyc(1, 6, 0, "radd");
        cyc(1, 7, 0, "radd"); cyc(1, 0, 0, "radd");

        // -------------------------------------------------- lw, 3 wait cycles
        do_reset("lw");
        bus.op = 6'b100011;
        cyc(1, 0, 0, "lw"); cyc(1, 1, 0, "lw"); cyc(1, 2, 0, "lw");
        cyc(0, 3, 0, "lw wait"); cyc(0, 3, 0, "lw wait"); cyc(0, 3, 0, "lw wait");
        cyc(1, 3, 0, "lw rdy"); cyc(0, 4, 0, "lw wb"); cyc(1, 0, 0, "lw");

        // -------------------------------------------------- bn / beq
        do_reset("bn");
        bus.op = 6'b100101; bus.zero = 1'b0;
        cyc(1, 0, 0, "bn"); cyc(1, 1, 0, "bn"); cyc(1, 8, 0, "bn br"); cyc(1, 0, 0, "bn");
        bus.op = 6'b000100; bus.zero = 1'b1;
        cyc(1, 1, 0, "beq"); cyc(1, 8, 0, "beq br"); cyc(1, 0, 0, "beq"); cyc(1, 1, 0, "beq");

        // -------------------------------------------------- jrsal
        do_reset("jrsal");
        bus.op = 6'b011001;
        cyc(1, 0, 0, "jrsal"); cyc(1, 1, 0, "jrsal"); cyc(1, 10, 0, "jrsal");
        cyc(1, 11, 0, "jrsal wb"); cyc(1, 0, 0, "jrsal");

        // -------------------------------------------------- watchdog boundary: memready wins
        do_reset("wdok");
        bus.op = 6'b000000; bus.funct = 6'b100000;
        for (int k = 0; k < WAITMAX; k++) cyc(0, 0, 0, "wdok wait");
        cyc(1, 0, 0, "wdok rdy");
        cyc(1, 1, 0, "wdok decode");

        // -------------------------------------------------- watchdog trip
        do_reset("wd");
        for (int k = 0; k < WAITMAX + 1; k++) cyc(0, 0, 0, "wd wait");
        cyc(0, 15, 1, "wd trap"); cyc(1, 15, 1, "wd trap"); cyc(0, 15, 1, "wd trap");
        do_reset("wd clr");
        cyc(1, 0, 0, "wd after");

        // -------------------------------------------------- illegal op
        do_reset("ill");
        bus.op = 6'b111111;
        cyc(1, 0, 0, "ill"); cyc(1, 1, 0, "ill"); cyc(1, 15, 1, "ill trap"); cyc(1, 15, 1, "ill trap");

        // -------------------------------------------------- reset mid-MEMWR
        do_reset("swrst");
        bus.op = 6'b101011;
        cyc(1, 0, 0, "sw"); cyc(1, 1, 0, "sw"); cyc(1, 2, 0, "sw"); cyc(0, 5, 0, "sw wait");
        bus.memready = 1'b0;
        #1;
        chk("sw pre-rst memwrite", 32'(bus.memwrite), 32'd1);
        resetn = 1'b0;
        #1;
        chk("sw rst memwrite", 32'(bus.memwrite), 32'd0);
        chk("sw rst state", 32'(bus.state), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc(1, 0, 0, "sw after");

        // -------------------------------------------------- random instruction stream
        do_reset("rnd");
        for (int n = 0; n < 60; n++) begin
            int cls;
            logic [5:0] fn_list [5];
            fn_list[0] = 6'b100000; fn_list[1] = 6'b100010; fn_list[2] = 6'b100100;
            fn_list[3] = 6'b100101; fn_list[4] = 6'b101010;
            cls = $urandom_range(0, 6);
            q.delete();
            push_wait(0, rnd_delay());
            push_fix(1);
            case (cls)
                0: begin bus.op = 6'b000000; bus.funct = fn_list[$urandom_range(0, 4)];
                         push_fix(6); push_fix(7); end
                1: begin bus.op = 6'b000000; bus.funct = 6'b001000; push_fix(9); end
                2: begin bus.op = 6'b100011; push_fix(2); push_wait(3, rnd_delay()); push_fix(4); end
                3: begin bus.op = 6'b101011; push_fix(2); push_wait(5, rnd_delay()); end
                4: begin bus.op = 6'b000100; push_fix(8); end
                5: begin bus.op = 6'b100101; push_fix(8); end
                default: begin bus.op = 6'b011001; push_wait(10, rnd_delay()); push_fix(11); end
            endcase
            while (q.size() > 0) begin
                step_t s;
                s = q.pop_front();
                bus.zero = 1'($urandom_range(0, 1));
                cyc(s.mr, s.st, 1'b0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
